inst_fetch_pipe: RTL and testbench

INST_FETCH_PIPE -- requirements
Module: inst_fetch_pipe

---
 rtl/inst_fetch_pipe.sv | 130 +++++++++++++
 tb/tb_inst_fetch_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_pipe.sv
// inst_fetch_pipe
// ----------------
// Single-stage instruction fetch unit with a private, loadable instruction
// memory. Each cycle it may fetch one word at the current PC into an output
// holding register, which the consumer drains with a valid/ready handshake.
// A branch redirect flushes the holding register and retargets the PC.
// Addresses beyond the memory depth still fetch, but they return zero and
// raise fault_o.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : asynchronous, active-low reset
//   stall_i        : suppress new fetches while high
//   branch_en_i    : redirect request (beats stall and fetch)
//   branch_addr_i  : redirect byte address (low two bits ignored)
//   inst_ready_i   : consumer takes inst_o this cycle
//   wr_en_i        : instruction-memory write strobe
//   wr_addr_i      : instruction-memory word index
//   wr_data_i      : instruction-memory write data
//   inst_valid_o   : inst_o / pc_o / fault_o hold a fetched instruction
//   inst_o         : fetched instruction
//   pc_o           : byte address of inst_o
//   fault_o        : inst_o came from an address outside the memory

module inst_fetch_pipe #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter int              MEM_AW   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              inst_ready_i,
  input  logic              wr_en_i,
  input  logic [MEM_AW-1:0] wr_addr_i,
  input  logic [INST_W-1:0] wr_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fault_o
);

  // Instruction storage; deliberately not reset so a program loaded
  // before or during reset survives it.
  logic [INST_W-1:0] mem_q [0:(1<<MEM_AW)-1];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pcOut_q, pcOut_d;
  logic              fault_q, fault_d;

  logic              accept;
  logic              space;
  logic              doFetch;
  logic [ADDR_W-1:0] pcUpper;
  logic              inRange;
  logic [INST_W-1:0] memWord;

  // The write port is independent of fetch; a fetch of the same word on
  // the same edge reads the value from before the write.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A shift rather than a part-select keeps this legal when the memory
  // covers the whole address space (no upper bits left, never faults).
  assign pcUpper = pc_q >> (MEM_AW + 2);
  assign inRange = (pcUpper == '0);
  assign memWord = mem_q[pc_q[MEM_AW+1:2]];

  assign accept  = valid_q & inst_ready_i;
  assign space   = ~valid_q | inst_ready_i;
  assign doFetch = ~branch_en_i & ~stall_i & space;

  // Next-state: branch flushes and redirects, fetch refills the holding
  // register, otherwise an accepted instruction simply drains.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    pcOut_d = pcOut_q;
    fault_d = fault_q;
    if (branch_en_i) begin
      pc_d    = {branch_addr_i[ADDR_W-1:2], 2'b00};
      valid_d = 1'b0;
    end else if (doFetch) begin
      valid_d = 1'b1;
      pcOut_d = pc_q;
      pc_d    = pc_q + ADDR_W'(4);
      if (inRange) begin
        inst_d  = memWord;
        fault_d = 1'b0;
      end else begin
        inst_d  = '0;
        fault_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // Reset drops any held instruction and pending redirect immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= '0;
      pcOut_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pcOut_q <= pcOut_d;
      fault_q <= fault_d;
    end
  end

  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pcOut_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_inst_fetch_pipe.sv
// tb_inst_fetch_pipe
// ------------------
// Directed bench for inst_fetch_pipe with default parameters. Expected
// accepted instructions are queued as the stimulus is set up and popped by
// a monitor whenever the handshake completes; directed checks cover reset,
// hold under backpressure, stall, branch, out-of-range and async reset.

module tb_inst_fetch_pipe;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_en_i;
  logic [31:0] branch_addr_i;
  logic        inst_ready_i;
  logic        wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fault_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  inst_fetch_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .branch_en_i  (branch_en_i),
    .branch_addr_i(branch_addr_i),
    .inst_ready_i (inst_ready_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .fault_o      (fault_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison of the bench funnels through here.
  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] inst, input logic f);
    checkEq({tag, "_valid"}, {31'd0, inst_valid_o}, {31'd0, v});
    checkEq({tag, "_pc"},    pc_o,                  pc);
    checkEq({tag, "_inst"},  inst_o,                inst);
    checkEq({tag, "_fault"}, {31'd0, fault_o},      {31'd0, f});
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] inst, input logic f);
    exp_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.fault = f;
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable at the falling edge; a valid+ready pair seen here
  // is an acceptance at the coming rising edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && inst_valid_o === 1'b1 && inst_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("[TB] FAIL sb_unexpected observed_pc=%0h expected=none", pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkEq("sb_pc",    pc_o,              e.pc);
        checkEq("sb_inst",  inst_o,            e.inst);
        checkEq("sb_fault", {31'd0, fault_o},  {31'd0, e.fault});
      end
    end
  end

  logic [9:0]  loadIdx  [11];
  logic [31:0] loadData [11];

  initial begin
    loadIdx  = '{10'h0, 10'h1, 10'h2, 10'h3, 10'h4, 10'h5, 10'h6, 10'h7,
                 10'h40, 10'h41, 10'h42};
    loadData = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88,
                 32'hA0, 32'hA1, 32'hA2};

    rst           = 1'b1;
    stall_i       = 1'b1;
    branch_en_i   = 1'b0;
    branch_addr_i = '0;
    inst_ready_i  = 1'b0;
    wr_en_i       = 1'b0;
    wr_addr_i     = '0;
    wr_data_i     = '0;
    #1 rst = 1'b0;
    #2;
    checkOutput("reset", 1'b0, 32'h0, 32'h0, 1'b0);

    // Program load while held in reset.
    for (int i = 0; i < 11; i++) begin
      wr_en_i   = 1'b1;
      wr_addr_i = loadIdx[i];
      wr_data_i = loadData[i];
      applyStimulus();
    end
    wr_en_i = 1'b0;
    checkOutput("reset_hold", 1'b0, 32'h0, 32'h0, 1'b0);

    // Release: first fetch from RESET_PC on the first edge.
    $display("[TB] sequential fetch and backpressure");
    rst          = 1'b1;
    stall_i      = 1'b0;
    inst_ready_i = 1'b1;
    pushExp(32'h0, 32'h11, 1'b0);
    pushExp(32'h4, 32'h22, 1'b0);
    applyStimulus();
    checkOutput("first", 1'b1, 32'h0, 32'h11, 1'b0);
    applyStimulus();
    checkOutput("seq4", 1'b1, 32'h4, 32'h22, 1'b0);
    inst_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("bp_hold", 1'b1, 32'h4, 32'h22, 1'b0);
    end
    inst_ready_i = 1'b1;
    pushExp(32'h8, 32'h33, 1'b0);
    applyStimulus();
    checkOutput("bp_resume", 1'b1, 32'h8, 32'h33, 1'b0);
    pushExp(32'hC, 32'h44, 1'b0);
    applyStimulus();
    checkOutput("seqC", 1'b1, 32'hC, 32'h44, 1'b0);

    // Stall: the held word drains, nothing new is fetched.
    $display("[TB] stall");
    stall_i = 1'b1;
    applyStimulus();
    checkOutput("stall1", 1'b0, 32'hC, 32'h44, 1'b0);
    applyStimulus();
    checkOutput("stall2", 1'b0, 32'hC, 32'h44, 1'b0);
    stall_i = 1'b0;
    pushExp(32'h10, 32'h55, 1'b0);
    applyStimulus();
    checkOutput("stall_resume", 1'b1, 32'h10, 32'h55, 1'b0);

    // Branch under stall to an unaligned target.
    $display("[TB] branch");
    stall_i       = 1'b1;
    branch_en_i   = 1'b1;
    branch_addr_i = 32'h0000_0103;
    applyStimulus();
    branch_en_i = 1'b0;
    stall_i     = 1'b0;
    checkOutput("br_flush", 1'b0, 32'h10, 32'h55, 1'b0);
    pushExp(32'h100, 32'hA0, 1'b0);
    pushExp(32'h104, 32'hA1, 1'b0);
    applyStimulus();
    checkOutput("br_tgt", 1'b1, 32'h100, 32'hA0, 1'b0);
    applyStimulus();
    checkOutput("br_next", 1'b1, 32'h104, 32'hA1, 1'b0);

    // Write and fetch of word 0x42 on the same edge: old data fetched.
    wr_en_i   = 1'b1;
    wr_addr_i = 10'h42;
    wr_data_i = 32'hEE;
    pushExp(32'h108, 32'hA2, 1'b0);
    applyStimulus();
    wr_en_i = 1'b0;
    checkOutput("rdw_old", 1'b1, 32'h108, 32'hA2, 1'b0);

    // Out-of-range fetches fault and return zero.
    $display("[TB] out of range");
    branch_en_i   = 1'b1;
    branch_addr_i = 32'h0000_1000;
    applyStimulus();
    branch_en_i = 1'b0;
    pushExp(32'h1000, 32'h0, 1'b1);
    pushExp(32'h1004, 32'h0, 1'b1);
    applyStimulus();
    checkOutput("oor0", 1'b1, 32'h1000, 32'h0, 1'b1);
    applyStimulus();
    checkOutput("oor1", 1'b1, 32'h1004, 32'h0, 1'b1);
    branch_en_i   = 1'b1;
    branch_addr_i = 32'h0000_0108;
    applyStimulus();
    branch_en_i = 1'b0;
    pushExp(32'h108, 32'hEE, 1'b0);
    applyStimulus();
    checkOutput("rdw_new", 1'b1, 32'h108, 32'hEE, 1'b0);

    // Async reset between edges with a held word and a pending branch.
    $display("[TB] async reset");
    inst_ready_i  = 1'b0;
    branch_en_i   = 1'b1;
    branch_addr_i = 32'h0000_0200;
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus();
    checkOutput("async_hold", 1'b0, 32'h0, 32'h0, 1'b0);
    rst          = 1'b1;
    branch_en_i  = 1'b0;
    inst_ready_i = 1'b1;
    pushExp(32'h0, 32'h11, 1'b0);
    pushExp(32'h4, 32'h22, 1'b0);
    applyStimulus();
    checkOutput("rst_refetch", 1'b1, 32'h0, 32'h11, 1'b0);
    applyStimulus();
    checkOutput("rst_seq4", 1'b1, 32'h4, 32'h22, 1'b0);
    stall_i = 1'b1;
    applyStimulus();
    applyStimulus();
    checkEq("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
